// File: rtl/multi_enemy_hit_judge_pkg.sv
// Shared types and default geometry/timing for the multi-enemy hit judge.
// Holds the per-enemy lifecycle state enum and the default parameter values
// used by the top level and the per-enemy lifecycle FSM.
package mehj_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIVE  = 3'd1,
    BOOM   = 3'd2,
    DEAD   = 3'd3,
    REVIVE = 3'd4
  } life_state_e;

  localparam int DEF_N_ENEMY     = 4;
  localparam int DEF_N_BULLET    = 8;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_HP_W        = 3;
  localparam int DEF_Y_OFFSET    = 480;
  localparam int DEF_HIT_XL      = 10;
  localparam int DEF_HIT_XR      = 50;
  localparam int DEF_HIT_YT      = 40;
  localparam int DEF_HIT_YB      = 50;
  localparam int DEF_BOOM_CYC    = 67108864;
  localparam int DEF_RESPAWN_CYC = 1024;
  localparam int DEF_REVIVE_CYC  = 750000;
  localparam int KILL_CNT_W      = 16;

endpackage

// File: rtl/multi_enemy_hit_judge_life_fsm.sv
// enemy_life_fsm: lifecycle of one enemy channel.
// Ports:
//   clk, rst     clock, async active-high reset
//   en           enemy channel present; low forces IDLE on the next edge
//   hit          this enemy is damaged this cycle (already priority-resolved)
//   health_init  health loaded on spawn and on revive (0 loads as 1)
//   health       registered current health
//   alive/boom/revive  registered state flags
//   hit_pulse    registered 1-cycle damage pulse
//   kill         combinational: the hit this cycle is the killing blow
module enemy_life_fsm
  import mehj_pkg::*;
#(
  parameter int HP_W        = DEF_HP_W,
  parameter int BOOM_CYC    = DEF_BOOM_CYC,
  parameter int RESPAWN_CYC = DEF_RESPAWN_CYC,
  parameter int REVIVE_CYC  = DEF_REVIVE_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            hit,
  input  logic [HP_W-1:0] health_init,
  output logic [HP_W-1:0] health,
  output logic            alive,
  output logic            boom,
  output logic            revive,
  output logic            hit_pulse,
  output logic            kill
);

  localparam int MAX_CYC = (BOOM_CYC > RESPAWN_CYC)
                         ? ((BOOM_CYC > REVIVE_CYC) ? BOOM_CYC : REVIVE_CYC)
                         : ((RESPAWN_CYC > REVIVE_CYC) ? RESPAWN_CYC : REVIVE_CYC);
  localparam int TIMER_W = $clog2(MAX_CYC + 1);

  // Timers count up from 0; a phase ends on the edge where the timer shows its last value.
  localparam logic [TIMER_W-1:0] BOOM_LAST    = TIMER_W'(BOOM_CYC - 1);
  localparam logic [TIMER_W-1:0] RESPAWN_LAST = TIMER_W'(RESPAWN_CYC - 1);
  localparam logic [TIMER_W-1:0] REVIVE_LAST  = TIMER_W'(REVIVE_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1'b1);
  localparam logic [HP_W-1:0]    HP_ONE       = HP_W'(1'b1);

  life_state_e       state_r, state_next_s;
  logic [TIMER_W-1:0] timer_r, timer_next_s;
  logic [HP_W-1:0]    health_r, health_next_s, health_load_s;
  logic               hit_pulse_r, hit_pulse_next_s;
  logic               alive_r, boom_r, revive_r;

  // A zero initial health would spawn an enemy that cannot be killed; load 1 instead.
  assign health_load_s = (health_init == {HP_W{1'b0}}) ? HP_ONE : health_init;

  // Next-state, timer, health and kill decode for the lifecycle.
  always_comb begin
    state_next_s     = state_r;
    timer_next_s     = timer_r;
    health_next_s    = health_r;
    hit_pulse_next_s = 1'b0;
    kill             = 1'b0;
    if (!en) begin
      state_next_s  = IDLE;
      timer_next_s  = {TIMER_W{1'b0}};
      health_next_s = {HP_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s  = ALIVE;
          timer_next_s  = {TIMER_W{1'b0}};
          health_next_s = health_load_s;
        end
        ALIVE: begin
          if (hit) begin
            hit_pulse_next_s = 1'b1;
            if (health_r <= HP_ONE) begin
              health_next_s = {HP_W{1'b0}};
              state_next_s  = BOOM;
              timer_next_s  = {TIMER_W{1'b0}};
              kill          = 1'b1;
            end else begin
              health_next_s = health_r - HP_ONE;
            end
          end else begin
            health_next_s = health_r;
          end
        end
        BOOM: begin
          if (timer_r == BOOM_LAST) begin
            state_next_s = DEAD;
            timer_next_s = {TIMER_W{1'b0}};
          end else begin
            timer_next_s = timer_r + TIMER_ONE;
          end
        end
        DEAD: begin
          if (timer_r == RESPAWN_LAST) begin
            state_next_s  = REVIVE;
            timer_next_s  = {TIMER_W{1'b0}};
            health_next_s = health_load_s;
          end else begin
            timer_next_s = timer_r + TIMER_ONE;
          end
        end
        REVIVE: begin
          if (timer_r == REVIVE_LAST) begin
            state_next_s = ALIVE;
            timer_next_s = {TIMER_W{1'b0}};
          end else begin
            timer_next_s = timer_r + TIMER_ONE;
          end
        end
        default: begin
          state_next_s  = IDLE;
          timer_next_s  = {TIMER_W{1'b0}};
          health_next_s = {HP_W{1'b0}};
        end
      endcase
    end
  end

  // State register plus registered flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      timer_r     <= {TIMER_W{1'b0}};
      health_r    <= {HP_W{1'b0}};
      hit_pulse_r <= 1'b0;
      alive_r     <= 1'b0;
      boom_r      <= 1'b0;
      revive_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      timer_r     <= timer_next_s;
      health_r    <= health_next_s;
      hit_pulse_r <= hit_pulse_next_s;
      alive_r     <= (state_next_s == ALIVE);
      boom_r      <= (state_next_s == BOOM);
      revive_r    <= (state_next_s == REVIVE);
    end
  end

  assign health    = health_r;
  assign hit_pulse = hit_pulse_r;
  assign alive     = alive_r;
  assign boom      = boom_r;
  assign revive    = revive_r;

endmodule

// File: rtl/multi_enemy_hit_judge.sv
// multi_enemy_hit_judge: bullet/enemy collision judge with per-enemy lifecycle.
// Ports:
//   clk, rst              clock, async active-high reset
//   ep_x, ep_y            packed enemy coordinates (y in enemy frame)
//   enemy_en              enemy channel present
//   health_init           packed per-enemy health loaded on spawn/revive
//   b_x, b_y, bullet_en   packed bullet coordinates and live flags
//   bullet_kill           registered pulse: bullet consumed
//   hit_pulse             registered pulse: enemy damaged
//   health, alive, boom, revive   per-enemy lifecycle outputs
//   kill_cnt              saturating total kill count
module multi_enemy_hit_judge
  import mehj_pkg::*;
#(
  parameter int N_ENEMY     = DEF_N_ENEMY,
  parameter int N_BULLET    = DEF_N_BULLET,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int HP_W        = DEF_HP_W,
  parameter int Y_OFFSET    = DEF_Y_OFFSET,
  parameter int HIT_XL      = DEF_HIT_XL,
  parameter int HIT_XR      = DEF_HIT_XR,
  parameter int HIT_YT      = DEF_HIT_YT,
  parameter int HIT_YB      = DEF_HIT_YB,
  parameter int BOOM_CYC    = DEF_BOOM_CYC,
  parameter int RESPAWN_CYC = DEF_RESPAWN_CYC,
  parameter int REVIVE_CYC  = DEF_REVIVE_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ENEMY*COORD_W-1:0]  ep_x,
  input  logic [N_ENEMY*COORD_W-1:0]  ep_y,
  input  logic [N_ENEMY-1:0]          enemy_en,
  input  logic [N_ENEMY*HP_W-1:0]     health_init,
  input  logic [N_BULLET*COORD_W-1:0] b_x,
  input  logic [N_BULLET*COORD_W-1:0] b_y,
  input  logic [N_BULLET-1:0]         bullet_en,
  output logic [N_BULLET-1:0]         bullet_kill,
  output logic [N_ENEMY-1:0]          hit_pulse,
  output logic [N_ENEMY*HP_W-1:0]     health,
  output logic [N_ENEMY-1:0]          alive,
  output logic [N_ENEMY-1:0]          boom,
  output logic [N_ENEMY-1:0]          revive,
  output logic [KILL_CNT_W-1:0]       kill_cnt
);

  // Two guard bits: one so ex-HIT_XL goes negative instead of wrapping, one for ey+offset+YB.
  localparam int CW = COORD_W + 2;

  logic [N_ENEMY-1:0][N_BULLET-1:0] hit_mat_s;
  logic [N_ENEMY-1:0][N_BULLET-1:0] sel_s;
  logic [N_ENEMY-1:0]               hit_s;
  logic [N_ENEMY-1:0]               kill_s;
  logic [N_BULLET-1:0]              bullet_kill_s;
  logic [N_BULLET-1:0]              bullet_kill_r;
  logic                             taken_s;
  logic                             got_s;
  logic                             win_s;
  logic [KILL_CNT_W:0]              kill_sum_s;
  logic [KILL_CNT_W-1:0]            kill_cnt_r;

  function automatic logic in_hitbox(input logic [COORD_W-1:0] ex,
                                     input logic [COORD_W-1:0] ey,
                                     input logic [COORD_W-1:0] bx,
                                     input logic [COORD_W-1:0] by);
    logic signed [CW-1:0] exs, eys, bxs, bys;
    exs = signed'({2'b00, ex});
    eys = signed'({2'b00, ey}) + signed'(CW'(Y_OFFSET));
    bxs = signed'({2'b00, bx});
    bys = signed'({2'b00, by});
    return (bxs >= exs - signed'(CW'(HIT_XL))) && (bxs < exs + signed'(CW'(HIT_XR))) &&
           (bys > eys - signed'(CW'(HIT_YT))) && (bys < eys + signed'(CW'(HIT_YB)));
  endfunction

  // Raw overlap of every live bullet with every present, hittable enemy.
  always_comb begin
    hit_mat_s = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      for (int j = 0; j < N_BULLET; j++) begin
        hit_mat_s[i][j] = bullet_en[j] & enemy_en[i] & alive[i] &
                          in_hitbox(ep_x[i*COORD_W +: COORD_W], ep_y[i*COORD_W +: COORD_W],
                                    b_x[j*COORD_W +: COORD_W], b_y[j*COORD_W +: COORD_W]);
      end
    end
  end

  // Two-stage priority: each bullet picks its lowest enemy, then each enemy keeps its
  // lowest bullet. Losing bullets of the second stage survive; they do not fall through.
  always_comb begin
    sel_s         = '0;
    hit_s         = '0;
    bullet_kill_s = '0;
    taken_s       = 1'b0;
    got_s         = 1'b0;
    win_s         = 1'b0;
    for (int j = 0; j < N_BULLET; j++) begin
      taken_s = 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
        sel_s[i][j] = hit_mat_s[i][j] & ~taken_s;
        taken_s     = taken_s | hit_mat_s[i][j];
      end
    end
    for (int i = 0; i < N_ENEMY; i++) begin
      got_s = 1'b0;
      for (int j = 0; j < N_BULLET; j++) begin
        win_s            = sel_s[i][j] & ~got_s;
        bullet_kill_s[j] = bullet_kill_s[j] | win_s;
        got_s            = got_s | sel_s[i][j];
      end
      hit_s[i] = got_s;
    end
  end

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    enemy_life_fsm #(
      .HP_W        (HP_W),
      .BOOM_CYC    (BOOM_CYC),
      .RESPAWN_CYC (RESPAWN_CYC),
      .REVIVE_CYC  (REVIVE_CYC)
    ) u_life (
      .clk         (clk),
      .rst         (rst),
      .en          (enemy_en[i]),
      .hit         (hit_s[i]),
      .health_init (health_init[i*HP_W +: HP_W]),
      .health      (health[i*HP_W +: HP_W]),
      .alive       (alive[i]),
      .boom        (boom[i]),
      .revive      (revive[i]),
      .hit_pulse   (hit_pulse[i]),
      .kill        (kill_s[i])
    );
  end

  // Add this cycle's kill popcount with one extra bit to detect saturation.
  always_comb begin
    kill_sum_s = {1'b0, kill_cnt_r};
    for (int i = 0; i < N_ENEMY; i++) begin
      kill_sum_s = kill_sum_s + {{KILL_CNT_W{1'b0}}, kill_s[i]};
    end
  end

  // Register bullet consumption and the saturating kill counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bullet_kill_r <= '0;
      kill_cnt_r    <= {KILL_CNT_W{1'b0}};
    end else begin
      bullet_kill_r <= bullet_kill_s;
      kill_cnt_r    <= kill_sum_s[KILL_CNT_W] ? {KILL_CNT_W{1'b1}} : kill_sum_s[KILL_CNT_W-1:0];
    end
  end

  assign bullet_kill = bullet_kill_r;
  assign kill_cnt    = kill_cnt_r;

endmodule

// File: tb/tb_multi_enemy_hit_judge.sv
`timescale 1ns/1ps
module tb_multi_enemy_hit_judge;

  localparam int NE = 4;
  localparam int NB = 8;
  localparam int CW = 10;
  localparam int HW = 3;
  localparam int BOOM_N = 8;
  localparam int RESP_N = 4;
  localparam int REV_N  = 4;
  localparam int P_IDLE = 0, P_ALIVE = 1, P_BOOM = 2, P_DEAD = 3, P_REVIVE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NE*CW-1:0] ep_x, ep_y;
  logic [NE-1:0]    enemy_en;
  logic [NE*HW-1:0] health_init;
  logic [NB*CW-1:0] b_x, b_y;
  logic [NB-1:0]    bullet_en;
  logic [NB-1:0]    bullet_kill;
  logic [NE-1:0]    hit_pulse, alive, boom, revive;
  logic [NE*HW-1:0] health;
  logic [15:0]      kill_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: lifecycle phase, cycles left in timed phase, health, kill total
  int m_phase[NE];
  int m_left[NE];
  int m_hp[NE];
  int m_kills;
  logic [NB-1:0] e_bk;
  logic [NE-1:0] e_pulse;

  int t2_bx[7]  = '{90, 150, 149, 100, 100, 100, 100};
  int t2_by[7]  = '{490, 490, 490, 440, 441, 530, 529};
  int t2_hit[7] = '{1, 0, 1, 0, 1, 0, 1};

  multi_enemy_hit_judge #(
    .N_ENEMY(NE), .N_BULLET(NB), .COORD_W(CW), .HP_W(HW),
    .Y_OFFSET(480), .HIT_XL(10), .HIT_XR(50), .HIT_YT(40), .HIT_YB(50),
    .BOOM_CYC(BOOM_N), .RESPAWN_CYC(RESP_N), .REVIVE_CYC(REV_N)
  ) dut (
    .clk(clk), .rst(rst), .ep_x(ep_x), .ep_y(ep_y), .enemy_en(enemy_en),
    .health_init(health_init), .b_x(b_x), .b_y(b_y), .bullet_en(bullet_en),
    .bullet_kill(bullet_kill), .hit_pulse(hit_pulse), .health(health),
    .alive(alive), .boom(boom), .revive(revive), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit overlaps(input int i, input int j);
    int ex, ey, bx, by;
    ex = int'(ep_x[i*CW +: CW]);
    ey = int'(ep_y[i*CW +: CW]) + 480;
    bx = int'(b_x[j*CW +: CW]);
    by = int'(b_y[j*CW +: CW]);
    return (bx >= ex - 10) && (bx < ex + 50) && (by > ey - 40) && (by < ey + 50);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_phase[i] = P_IDLE;
      m_left[i]  = 0;
      m_hp[i]    = 0;
    end
    m_kills = 0;
    e_bk    = '0;
    e_pulse = '0;
  endtask

  // Predict the effect of the next clock edge from current inputs and model state.
  task automatic model_eval();
    bit claimed[NE];
    int kills;
    int tgt;
    int init;
    kills   = 0;
    e_bk    = '0;
    e_pulse = '0;
    for (int i = 0; i < NE; i++) claimed[i] = 1'b0;
    for (int j = 0; j < NB; j++) begin
      if (bullet_en[j]) begin
        tgt = -1;
        for (int i = 0; i < NE; i++)
          if (tgt < 0 && enemy_en[i] && m_phase[i] == P_ALIVE && overlaps(i, j)) tgt = i;
        if (tgt >= 0 && !claimed[tgt]) begin
          claimed[tgt] = 1'b1;
          e_bk[j]      = 1'b1;
        end
      end
    end
    for (int i = 0; i < NE; i++) begin
      init = int'(health_init[i*HW +: HW]);
      if (init == 0) init = 1;
      if (!enemy_en[i]) begin
        m_phase[i] = P_IDLE; m_hp[i] = 0; m_left[i] = 0;
      end else begin
        case (m_phase[i])
          P_IDLE: begin m_phase[i] = P_ALIVE; m_hp[i] = init; end
          P_ALIVE: if (claimed[i]) begin
            e_pulse[i] = 1'b1;
            if (m_hp[i] == 1) begin
              m_hp[i] = 0; m_phase[i] = P_BOOM; m_left[i] = BOOM_N; kills++;
            end else m_hp[i]--;
          end
          P_BOOM: begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_phase[i] = P_DEAD; m_left[i] = RESP_N; end
          end
          P_DEAD: begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_phase[i] = P_REVIVE; m_left[i] = REV_N; m_hp[i] = init; end
          end
          P_REVIVE: begin
            m_left[i]--;
            if (m_left[i] == 0) m_phase[i] = P_ALIVE;
          end
          default: m_phase[i] = P_IDLE;
        endcase
      end
    end
    m_kills = (m_kills + kills > 65535) ? 65535 : m_kills + kills;
  endtask

  task automatic check_all(input string tag);
    logic [NE*HW-1:0] e_health;
    logic [NE-1:0] e_alive, e_boom, e_rev;
    for (int i = 0; i < NE; i++) begin
      e_health[i*HW +: HW] = HW'(m_hp[i]);
      e_alive[i] = (m_phase[i] == P_ALIVE);
      e_boom[i]  = (m_phase[i] == P_BOOM);
      e_rev[i]   = (m_phase[i] == P_REVIVE);
    end
    check_val({tag, ".bullet_kill"}, 32'(bullet_kill), 32'(e_bk));
    check_val({tag, ".hit_pulse"}, 32'(hit_pulse), 32'(e_pulse));
    check_val({tag, ".health"}, 32'(health), 32'(e_health));
    check_val({tag, ".alive"}, 32'(alive), 32'(e_alive));
    check_val({tag, ".boom"}, 32'(boom), 32'(e_boom));
    check_val({tag, ".revive"}, 32'(revive), 32'(e_rev));
    check_val({tag, ".kill_cnt"}, 32'(kill_cnt), 32'(m_kills));
  endtask

  task automatic step(input string tag);
    model_eval();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_enemy(input int i, input int x, input int y, input int init, input bit en);
    ep_x[i*CW +: CW]        = CW'(x);
    ep_y[i*CW +: CW]        = CW'(y);
    health_init[i*HW +: HW] = HW'(init);
    enemy_en[i]             = en;
  endtask

  task automatic set_bullet(input int j, input int x, input int y, input bit en);
    b_x[j*CW +: CW] = CW'(x);
    b_y[j*CW +: CW] = CW'(y);
    bullet_en[j]    = en;
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int k, ex, ey;
    rst = 1'b1;
    ep_x = '0; ep_y = '0; enemy_en = '0; health_init = '0;
    b_x = '0; b_y = '0; bullet_en = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");
    check_val("reset.kill_cnt0", 32'(kill_cnt), 32'd0);

    // 1: single hit on enemy0
    set_enemy(0, 100, 0, 2, 1'b1);
    step("t1.spawn");
    set_bullet(0, 100, 490, 1'b1);
    step("t1.hit");
    check_val("t1.pulse", 32'(hit_pulse), 32'h1);
    check_val("t1.bkill", 32'(bullet_kill), 32'h01);
    check_val("t1.health0", 32'(health[2:0]), 32'd1);
    bullet_en = '0;
    step("t1.idle");

    // 2: hitbox edges, respawn enemy0 with health 7
    enemy_en[0] = 1'b0;
    step("t2.drop");
    set_enemy(0, 100, 0, 7, 1'b1);
    step("t2.spawn");
    for (int e = 0; e < 7; e++) begin
      set_bullet(0, t2_bx[e], t2_by[e], 1'b1);
      step("t2.edge");
      check_val("t2.edge_hit", 32'(hit_pulse[0]), 32'(t2_hit[e]));
    end
    set_enemy(0, 5, 0, 7, 1'b1);
    set_bullet(0, 0, 490, 1'b1);
    step("t2.nowrap");
    check_val("t2.nowrap_hit", 32'(hit_pulse[0]), 32'd1);
    check_val("t2.health0", 32'(health[2:0]), 32'd2);

    // 3: kill enemy0 and follow the full boom/dead/revive sequence
    set_enemy(0, 100, 0, 7, 1'b1);
    set_bullet(0, 100, 490, 1'b1);
    step("t3.hit1");
    step("t3.kill");
    check_val("t3.kill_cnt", 32'(kill_cnt), 32'd1);
    check_val("t3.health0", 32'(health[2:0]), 32'd0);
    bullet_en = '0;
    for (int c = 1; c <= 16; c++) begin
      step("t3.seq");
      check_val("t3.boom", 32'(boom[0]), 32'(c < 8));
      check_val("t3.revive", 32'(revive[0]), 32'(c >= 12 && c < 16));
      check_val("t3.alive", 32'(alive[0]), 32'(c >= 16));
    end
    check_val("t3.reload", 32'(health[2:0]), 32'd7);

    // 4: priority among bullets and among enemies
    set_enemy(1, 300, 100, 3, 1'b1);
    step("t4.spawn1");
    set_bullet(2, 310, 580, 1'b1);
    set_bullet(5, 320, 590, 1'b1);
    step("t4.two_bullets");
    check_val("t4.bkill", 32'(bullet_kill), 32'h04);
    check_val("t4.health1", 32'(health[5:3]), 32'd2);
    bullet_en = '0;
    set_enemy(3, 100, 0, 3, 1'b1);
    step("t4.spawn3");
    set_bullet(0, 100, 490, 1'b1);
    step("t4.overlap");
    check_val("t4.pulse", 32'(hit_pulse), 32'h1);
    check_val("t4.health3", 32'(health[11:9]), 32'd3);
    bullet_en = '0;
    step("t4.idle");

    // 5: drop enemy1 during BOOM, then async reset mid-REVIVE
    set_enemy(3, 0, 0, 0, 1'b0);
    set_bullet(2, 310, 580, 1'b1);
    step("t5.hit1");
    step("t5.kill1");
    bullet_en = '0;
    step("t5.boom_a");
    step("t5.boom_b");
    enemy_en[1] = 1'b0;
    step("t5.drop");
    check_val("t5.boom1", 32'(boom[1]), 32'd0);
    check_val("t5.health1", 32'(health[5:3]), 32'd0);
    enemy_en[0] = 1'b0;
    step("t5.drop0");
    set_enemy(0, 100, 0, 1, 1'b1);
    step("t5.spawn0");
    set_bullet(0, 100, 490, 1'b1);
    step("t5.kill0");
    bullet_en = '0;
    for (int c = 1; c <= 13; c++) step("t5.seq");
    check_val("t5.in_revive", 32'(revive[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5.rst_alive", 32'(alive), 32'd0);
    check_val("t5.rst_boom", 32'(boom), 32'd0);
    check_val("t5.rst_revive", 32'(revive), 32'd0);
    check_val("t5.rst_health", 32'(health), 32'd0);
    check_val("t5.rst_kill_cnt", 32'(kill_cnt), 32'd0);
    check_val("t5.rst_pulses", 32'({hit_pulse, bullet_kill}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 6: simultaneous kills and saturation
    set_enemy(0, 100, 0, 1, 1'b1);
    set_enemy(2, 600, 200, 1, 1'b1);
    step("t6.spawn");
    set_bullet(0, 100, 490, 1'b1);
    set_bullet(1, 600, 690, 1'b1);
    step("t6.double");
    check_val("t6.kill_cnt2", 32'(kill_cnt), 32'd2);
    bullet_en = '0;
    force dut.kill_cnt_r = 16'hFFFE;
    #1;
    release dut.kill_cnt_r;
    m_kills = 65534;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 16; c++) step("t6.wait");
      bullet_en = 8'h03;
      step("t6.sat_kill");
      check_val("t6.sat", 32'(kill_cnt), 32'hFFFF);
      bullet_en = '0;
    end

    // randomized stimulus against the model
    sync_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 40 == 0) begin
        for (int i = 0; i < NE; i++)
          set_enemy(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 500)),
                    int'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
      end
      for (int j = 0; j < NB; j++) begin
        k = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          ex = int'(ep_x[k*CW +: CW]);
          ey = int'(ep_y[k*CW +: CW]) + 480;
          set_bullet(j, clamp(ex + int'($urandom_range(0, 70)) - 15),
                     clamp(ey + int'($urandom_range(0, 100)) - 45), 1'b1);
        end else begin
          set_bullet(j, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     ($urandom_range(0, 1) == 1));
        end
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
